// File: rtl/br_ram_data_rd_pipe_flow.sv
// Tiled RAM read-data join (width then depth staging) into a credited in-order output FIFO.
// Latency DepthStages+WidthStages+1 tile-to-out_valid; out_ready backpressure, credits bound the FIFO.
module br_ram_data_rd_pipe_flow #(
    parameter int Width       = 1,
    parameter int DepthTiles  = 1,
    parameter int WidthTiles  = 1,
    parameter int DepthStages = 0,
    parameter int WidthStages = 0,
    parameter int BufferDepth = 2,
    localparam int TileWidth  = Width / WidthTiles,
    localparam int CW         = $clog2(BufferDepth + 1)
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    rd_issue,
    output logic                                    rd_credit_avail,
    output logic [CW-1:0]                           credit_count,
    input  logic [DepthTiles*WidthTiles-1:0]        tile_valid,
    input  logic [DepthTiles*WidthTiles*TileWidth-1:0] tile_data,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [Width-1:0]                        out_data,
    output logic                                    error_lockstep,
    output logic                                    error_multirow,
    output logic                                    error_overflow
);
    localparam int NT = DepthTiles * WidthTiles;
    localparam int PW = (BufferDepth > 1) ? $clog2(BufferDepth) : 1;

    // Width staging: tile t = row*WidthTiles + col, so each row's tiles form a contiguous Width slice.
    logic [WidthStages:0][NT-1:0]           wv;
    logic [WidthStages:0][NT*TileWidth-1:0] wd;
    assign wv[0] = tile_valid;
    assign wd[0] = tile_data;

    for (genvar s = 0; s < WidthStages; s++) begin : g_wstage
        logic [NT-1:0]           v_q;
        logic [NT*TileWidth-1:0] d_q;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) v_q <= '0;
            else     v_q <= wv[s];
        end
        always_ff @(posedge clk) begin
            for (int t = 0; t < NT; t++) begin
                if (wv[s][t]) d_q[t*TileWidth +: TileWidth] <= wd[s][t*TileWidth +: TileWidth];
            end
        end
        assign wv[s+1] = v_q;
        assign wd[s+1] = d_q;
    end

    logic [DepthStages:0][DepthTiles-1:0]       rv;
    logic [DepthStages:0][DepthTiles*Width-1:0] rdat;
    for (genvar d = 0; d < DepthTiles; d++) begin : g_row
        assign rv[0][d] = |wv[WidthStages][d*WidthTiles +: WidthTiles];
    end
    assign rdat[0] = wd[WidthStages];

    for (genvar s = 0; s < DepthStages; s++) begin : g_dstage
        logic [DepthTiles-1:0]       v_q;
        logic [DepthTiles*Width-1:0] d_q;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) v_q <= '0;
            else     v_q <= rv[s];
        end
        always_ff @(posedge clk) begin
            for (int d = 0; d < DepthTiles; d++) begin
                if (rv[s][d]) d_q[d*Width +: Width] <= rdat[s][d*Width +: Width];
            end
        end
        assign rv[s+1]   = v_q;
        assign rdat[s+1] = d_q;
    end

    logic             join_vld;
    logic [Width-1:0] join_dat;
    always_comb begin
        join_vld = |rv[DepthStages];
        join_dat = '0;
        for (int d = DepthTiles - 1; d >= 0; d--) begin
            if (rv[DepthStages][d]) join_dat = rdat[DepthStages][d*Width +: Width];
        end
    end

    logic                  lock_bad, multi_bad, row_seen;
    logic [WidthTiles-1:0] row_v;
    always_comb begin
        lock_bad  = 1'b0;
        multi_bad = 1'b0;
        row_seen  = 1'b0;
        row_v     = '0;
        for (int d = 0; d < DepthTiles; d++) begin
            row_v = tile_valid[d*WidthTiles +: WidthTiles];
            if (row_v != '0 && row_v != '1) lock_bad = 1'b1;
            if (row_v != '0) begin
                if (row_seen) multi_bad = 1'b1;
                row_seen = 1'b1;
            end
        end
    end

    logic [Width-1:0] mem [BufferDepth];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d, credit_q, credit_d;
    logic             full, push, pop, ovf;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(BufferDepth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full      = (count_q == CW'(BufferDepth));
    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
    assign push      = join_vld && (!full || pop);
    assign ovf       = (rd_issue && credit_q == '0 && !pop) || (join_vld && full && !pop);
    assign out_data  = mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) count_d = count_q + 1'b1;
        if (pop && !push) count_d = count_q - 1'b1;
        credit_d = credit_q;
        if (rd_issue && !pop && credit_q != '0)            credit_d = credit_q - 1'b1;
        if (pop && !rd_issue && credit_q != CW'(BufferDepth)) credit_d = credit_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= join_dat;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            credit_q       <= CW'(BufferDepth);
            error_lockstep <= 1'b0;
            error_multirow <= 1'b0;
            error_overflow <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            credit_q       <= credit_d;
            error_lockstep <= error_lockstep | lock_bad;
            error_multirow <= error_multirow | multi_bad;
            error_overflow <= error_overflow | ovf;
        end
    end

    assign credit_count    = credit_q;
    assign rd_credit_avail = (credit_q != '0);
endmodule

// File: tb/tb_br_ram_data_rd_pipe_flow.sv
// Directed bench for the 2x2-tile, 1+1 stage, 4-entry configuration with an output scoreboard.
module tb_br_ram_data_rd_pipe_flow;
    logic        clk = 1'b0;
    logic        rst;
    logic        rd_issue;
    logic        rd_credit_avail;
    logic [2:0]  credit_count;
    logic [3:0]  tile_valid;
    logic [15:0] tile_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        error_lockstep, error_multirow, error_overflow;

    int total = 0;
    int bad   = 0;
    logic [7:0] sb [$];

    br_ram_data_rd_pipe_flow #(
        .Width(8), .DepthTiles(2), .WidthTiles(2),
        .DepthStages(1), .WidthStages(1), .BufferDepth(4)
    ) dut (
        .clk(clk), .rst(rst), .rd_issue(rd_issue),
        .rd_credit_avail(rd_credit_avail), .credit_count(credit_count),
        .tile_valid(tile_valid), .tile_data(tile_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .error_lockstep(error_lockstep), .error_multirow(error_multirow),
        .error_overflow(error_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_checks();
        check("rst_out_valid", out_valid, 0);
        check("rst_credit", credit_count, 4);
        check("rst_avail", rd_credit_avail, 1);
        check("rst_errors", {error_lockstep, error_multirow, error_overflow}, 0);
    endtask

    // Pulse reset between clock edges; outputs must clear without waiting for a clock.
    task automatic do_reset();
        #2;
        rst        = 1'b1;
        tile_valid = '0;
        rd_issue   = 1'b0;
        sb.delete();
        #1;
        reset_checks();
        #1;
        rst = 1'b0;
        step();
    endtask

    always @(negedge clk) begin
        logic [7:0] e;
        if (!rst && out_valid && out_ready) begin
            e = (sb.size() > 0) ? sb.pop_front() : 8'hEE;
            check("sb_out_data", out_data, e);
        end
    end

    initial begin
        rst = 1'b1; rd_issue = 1'b0; tile_valid = '0; tile_data = '0; out_ready = 1'b0;
        #3;
        reset_checks();
        #4 rst = 1'b0;
        step();

        // Single read round trip.
        out_ready = 1'b1;
        rd_issue  = 1'b1;
        step();
        rd_issue = 1'b0;
        check("t1_credit_after_issue", credit_count, 3);
        step(); step();
        tile_valid = 4'b1100; tile_data = 16'hA500; sb.push_back(8'hA5);
        step();
        tile_valid = '0;
        step();
        check("t1_latency_not_early", out_valid, 0);
        step();
        check("t1_out_valid", out_valid, 1);
        check("t1_out_data", out_data, 8'hA5);
        step();
        check("t1_credit_back", credit_count, 4);
        check("t1_drained", out_valid, 0);

        // Fill all credits and the buffer under backpressure, then drain.
        out_ready = 1'b0;
        repeat (4) begin rd_issue = 1'b1; step(); end
        rd_issue = 1'b0;
        check("t2_credit_zero", credit_count, 0);
        check("t2_avail_low", rd_credit_avail, 0);
        for (int i = 1; i <= 4; i++) begin
            tile_valid = 4'b0011; tile_data = 16'(i); sb.push_back(8'(i));
            step();
        end
        tile_valid = '0;
        step(); step();
        check("t2_hold_valid", out_valid, 1);
        check("t2_hold_data", out_data, 8'h01);
        step();
        check("t2_hold_stable", out_data, 8'h01);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t2_consecutive_valid", out_valid, 1);
            step();
        end
        check("t2_empty", out_valid, 0);
        check("t2_credit_full", credit_count, 4);

        // Issue and pop in the same cycle at credit 2.
        out_ready = 1'b0;
        rd_issue  = 1'b1;
        step(); step();
        rd_issue   = 1'b0;
        tile_valid = 4'b0011; tile_data = 16'h0033; sb.push_back(8'h33);
        step();
        tile_valid = '0;
        step(); step();
        check("t3_credit_two", credit_count, 2);
        check("t3_valid", out_valid, 1);
        rd_issue = 1'b1; out_ready = 1'b1;
        step();
        rd_issue = 1'b0; out_ready = 1'b0;
        check("t3_credit_same", credit_count, 2);
        check("t3_no_error", error_overflow, 0);

        // Issue with no credits left.
        rd_issue = 1'b1;
        step(); step();
        check("t4_credit_zero", credit_count, 0);
        check("t4_no_error_yet", error_overflow, 0);
        step();
        rd_issue = 1'b0;
        check("t4_overflow_set", error_overflow, 1);
        check("t4_credit_stays", credit_count, 0);
        step();
        check("t4_overflow_sticky", error_overflow, 1);

        // Fifth return into a full buffer is dropped; the first four survive in order.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tile_valid = 4'b0011; tile_data = 16'(8'h41 + i);
            if (i < 4) sb.push_back(8'(8'h41 + i));
            step();
        end
        tile_valid = '0;
        step(); step();
        check("t5_full_overflow", error_overflow, 1);
        check("t5_head", out_data, 8'h41);
        out_ready = 1'b1;
        repeat (5) step();
        check("t5_drained", out_valid, 0);
        check("t5_sb_empty", sb.size(), 0);

        // Error flags, lowest-row select, and reset with buffered and in-flight data.
        do_reset();
        out_ready  = 1'b0;
        tile_valid = 4'b1111; tile_data = 16'h2211;
        step();
        check("t6_multirow", error_multirow, 1);
        check("t6_no_lockstep", error_lockstep, 0);
        tile_valid = 4'b0001; tile_data = 16'h0077;
        step();
        check("t6_lockstep", error_lockstep, 1);
        tile_valid = 4'b1100; tile_data = 16'h5500;
        step();
        check("t6_valid", out_valid, 1);
        check("t6_lowest_row", out_data, 8'h11);
        step();
        check("t6_two_buffered", out_valid, 1);
        do_reset();
        repeat (5) step();
        check("t6_no_ghost_output", out_valid, 0);
        check("t6_credit_after_reset", credit_count, 4);

        check("final_not_valid", out_valid, 0);
        check("final_sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/br_ram_data_rd_pipe_flow.md
BR_RAM_DATA_RD_PIPE_FLOW -- requirements
Module: br_ram_data_rd_pipe_flow

Interface
REQ-001 Width, 1, bits per RAM entry; SHALL be >=1.
REQ-002 DepthTiles, 1, tiles along depth; SHALL be >=1.
REQ-003 WidthTiles, 1, tiles along width; SHALL be >=1 and evenly divide Width; TileWidth = Width/WidthTiles.
REQ-004 DepthStages, 0, register stages before depth mux; SHALL be >=0.
REQ-005 WidthStages, 0, register stages before width concat; SHALL be >=0.
REQ-006 BufferDepth, 2, output buffer entries; SHALL be >=1; CW = clog2(BufferDepth+1).
REQ-007 clk  in  1  posedge clock; the block has one clock.
REQ-008 rst  in  1  reset, asynchronous and active-high.
REQ-009 rd_issue  in  1  pulse: one read issued to the RAM this cycle.
REQ-010 rd_credit_avail  out  1  high when credit_count != 0.
REQ-011 credit_count  out  CW  free buffer credits.
REQ-012 tile_valid  in  DepthTiles x WidthTiles  per-tile read-data valid.
REQ-013 tile_data  in  DepthTiles x WidthTiles x TileWidth  per-tile read data.
REQ-014 out_valid  out  1  output data valid.
REQ-015 out_ready  in  1  consumer ready.
REQ-016 out_data  out  Width  output data.
REQ-017 error_lockstep  out  1  sticky: partial width valids seen in a row.
REQ-018 error_multirow  out  1  sticky: more than one depth row valid.
REQ-019 error_overflow  out  1  sticky: issue without credit or write to full buffer.

Function
REQ-020 Each tile SHALL pass through WidthStages valid-gated registers; row d valid = OR of its delayed width valids; row data = concat of delayed tile data, tile 0 in LSBs.
REQ-021 Each row SHALL pass through DepthStages valid-gated registers; joined valid = OR of delayed row valids; joined data = lowest-index valid row's data.
REQ-022 Join latency L = DepthStages + WidthStages; L=0 SHALL be purely combinational from tile inputs to buffer write port.
REQ-023 A joined valid SHALL write joined data into an in-order FIFO of BufferDepth entries the same cycle.
REQ-024 out_valid SHALL be high iff the FIFO is non-empty, registered, no bypass; total tile-to-out_valid latency = L+1.
REQ-025 Pop when out_valid && out_ready; out_data SHALL hold stable while out_valid && !out_ready.
REQ-026 FIFO write and pop in the same cycle SHALL both occur, including when full (pop frees the slot) and when holding one entry.
REQ-027 credit_count: rd_issue alone -> -1; pop alone -> +1; both or neither -> unchanged; never exceeds BufferDepth.
REQ-028 rd_issue with credit_count==0 and no same-cycle pop SHALL set error_overflow; count stays 0.
REQ-029 Joined valid with FIFO full and no same-cycle pop SHALL drop the data and set error_overflow.
REQ-030 error_lockstep SHALL set on any cycle where a row's input tile_valid is neither all-0 nor all-1.
REQ-031 error_multirow SHALL set on any cycle with >1 row having any input tile_valid high.
REQ-032 All error flags SHALL remain set until reset and SHALL NOT alter datapath behaviour.
REQ-033 FIFO pointers SHALL wrap modulo BufferDepth, including non-power-of-2 depths.

Reset
REQ-034 rst assertion SHALL immediately clear all stage valids, FIFO pointers/occupancy, out_valid, and errors, and set credit_count=BufferDepth, rd_credit_avail=1.
REQ-035 Data registers and FIFO storage SHALL NOT be reset; out_data is don't-care while out_valid=0.
REQ-036 In-flight reads at reset SHALL be discarded; no output appears after deassertion without new tile_valid.
REQ-037 When EnableAssertFinalNotValid=1, out_valid and all stage valids SHALL be low at end of test.

Verification (Width=8, DepthTiles=2, WidthTiles=2, DepthStages=1, WidthStages=1, BufferDepth=4)
REQ-038 rd_issue at cycle 0; tile_valid[1]=2'b11, tile_data[1]={4'hA,4'h5} at cycle 3, out_ready=1 -> credit_count 3 from cycle 1; out_valid=1, out_data=8'hA5 at cycle 6; credit_count 4 at cycle 7.
REQ-039 4 issues, out_ready=0, 4 returns with data 8'h01..8'h04 -> credit_count 0, rd_credit_avail 0; out_ready=1 -> outputs 01,02,03,04 in consecutive cycles, credit_count back to 4.
REQ-040 credit_count=2, rd_issue and pop same cycle -> credit_count stays 2, no error.
REQ-041 credit_count=0, rd_issue without pop -> error_overflow=1, stays 1; credit_count=0.
REQ-042 tile_valid={2'b00,2'b01} -> error_lockstep=1; tile_valid={2'b11,2'b11}, row0=8'h11, row1=8'h22 -> error_multirow=1, out_data 8'h11.
REQ-043 2 entries buffered, rst pulsed mid-cycle -> out_valid 0 immediately, credit_count 4, errors 0.
